// File: rtl/vga_depth_dither.sv
// Colour-depth adapter: IN_W-bit RGB to OUT_W-bit RGB by truncate, round, Bayer or Bayer+temporal dither.
// Latency: 2 CE_PIX cycles for colour, HS, VS and DE (stage 1 threshold add, stage 2 saturate/slice).
// Backpressure: none; CE_PIX=0 freezes every register, outputs included.
module vga_depth_dither #(
    parameter int IN_W   = 8,
    parameter int OUT_W  = 6,
    parameter int MATRIX = 2,
    parameter bit SYNC_P = 1'b0
) (
    input  logic             CLOCK_27,
    input  logic             RESET_N,
    input  logic             CE_PIX,
    input  logic [1:0]       MODE,
    input  logic             HS_IN,
    input  logic             VS_IN,
    input  logic             DE_IN,
    input  logic [IN_W-1:0]  R_IN,
    input  logic [IN_W-1:0]  G_IN,
    input  logic [IN_W-1:0]  B_IN,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             VGA_DE,
    output logic [OUT_W-1:0] VGA_R,
    output logic [OUT_W-1:0] VGA_G,
    output logic [OUT_W-1:0] VGA_B
);

    localparam int D     = IN_W - OUT_W;
    localparam int LOG2N = (MATRIX == 4) ? 2 : 1;
    localparam int L     = 2 * LOG2N;
    localparam int SHL   = (D >= L) ? D - L : 0;
    localparam int SHR   = (D >= L) ? 0 : L - D;
    localparam int RSH   = (D >= 1) ? D - 1 : 0;
    localparam logic [31:0] RND_T = (D >= 1) ? (32'd1 << RSH) : 32'd0;

    if (OUT_W < 1 || OUT_W > IN_W) begin : g_bad_width
        $error("vga_depth_dither: OUT_W must satisfy 1 <= OUT_W <= IN_W");
    end
    if (MATRIX != 2 && MATRIX != 4) begin : g_bad_matrix
        $error("vga_depth_dither: MATRIX must be 2 or 4");
    end

    logic             hs_q, vs_q;
    logic [LOG2N-1:0] x, y;
    logic             had_de;
    logic             f;
    logic [1:0]       mode_q;

    logic             hs_lead, vs_lead;
    logic [LOG2N-1:0] xi, yi;
    logic [3:0]       m;
    logic [31:0]      t;
    logic [31:0]      sum_r, sum_g, sum_b;

    logic [IN_W:0]    s_r, s_g, s_b;
    logic             hs1, vs1, de1;

    // Edges compare the live input with the copy registered on the previous enabled pixel.
    assign hs_lead = (HS_IN == SYNC_P) && (hs_q != SYNC_P);
    assign vs_lead = (VS_IN == SYNC_P) && (vs_q != SYNC_P);

    assign xi = (mode_q == 2'b11) ? (x ^ LOG2N'(f)) : x;
    assign yi = (mode_q == 2'b11) ? (y ^ LOG2N'(f)) : y;

    if (MATRIX == 4) begin : g_bayer4
        always_comb begin
            m = 4'd0;
            case ({yi, xi})
                4'h0: m = 4'd0;   4'h1: m = 4'd8;   4'h2: m = 4'd2;   4'h3: m = 4'd10;
                4'h4: m = 4'd12;  4'h5: m = 4'd4;   4'h6: m = 4'd14;  4'h7: m = 4'd6;
                4'h8: m = 4'd3;   4'h9: m = 4'd11;  4'hA: m = 4'd1;   4'hB: m = 4'd9;
                4'hC: m = 4'd15;  4'hD: m = 4'd7;   4'hE: m = 4'd13;  default: m = 4'd5;
            endcase
        end
    end else begin : g_bayer2
        always_comb begin
            m = 4'd0;
            case ({yi, xi})
                2'b00:   m = 4'd0;
                2'b01:   m = 4'd2;
                2'b10:   m = 4'd3;
                default: m = 4'd1;
            endcase
        end
    end

    always_comb begin
        t = 32'd0;
        case (mode_q)
            2'b00:   t = 32'd0;
            2'b01:   t = RND_T;
            default: t = (32'(m) << SHL) >> SHR;
        endcase
        if (D == 0) t = 32'd0;
    end

    assign sum_r = 32'(R_IN) + t;
    assign sum_g = 32'(G_IN) + t;
    assign sum_b = 32'(B_IN) + t;

    // Bit IN_W of the stage-1 sum flags overflow; the rest is the unsaturated sum.
    function automatic logic [OUT_W-1:0] slice(input logic [IN_W:0] s);
        if (s[IN_W]) return '1;
        return OUT_W'(s[IN_W-1:0] >> D);
    endfunction

    always_ff @(posedge CLOCK_27 or negedge RESET_N) begin
        if (!RESET_N) begin
            hs_q   <= ~SYNC_P;
            vs_q   <= ~SYNC_P;
            x      <= '0;
            y      <= '0;
            had_de <= 1'b0;
            f      <= 1'b0;
            mode_q <= 2'b00;
        end else if (CE_PIX) begin
            hs_q <= HS_IN;
            vs_q <= VS_IN;
            x    <= DE_IN ? x + LOG2N'(1) : '0;
            if (vs_lead)                y <= '0;
            else if (hs_lead && had_de) y <= y + LOG2N'(1);
            had_de <= hs_lead ? 1'b0 : (had_de | DE_IN);
            if (vs_lead) begin
                f      <= ~f;
                mode_q <= MODE;
            end
        end
    end

    always_ff @(posedge CLOCK_27 or negedge RESET_N) begin
        if (!RESET_N) begin
            s_r    <= '0;
            s_g    <= '0;
            s_b    <= '0;
            hs1    <= ~SYNC_P;
            vs1    <= ~SYNC_P;
            de1    <= 1'b0;
            VGA_R  <= '0;
            VGA_G  <= '0;
            VGA_B  <= '0;
            VGA_HS <= ~SYNC_P;
            VGA_VS <= ~SYNC_P;
            VGA_DE <= 1'b0;
        end else if (CE_PIX) begin
            s_r    <= {|sum_r[31:IN_W], sum_r[IN_W-1:0]};
            s_g    <= {|sum_g[31:IN_W], sum_g[IN_W-1:0]};
            s_b    <= {|sum_b[31:IN_W], sum_b[IN_W-1:0]};
            hs1    <= HS_IN;
            vs1    <= VS_IN;
            de1    <= DE_IN;
            VGA_R  <= de1 ? slice(s_r) : '0;
            VGA_G  <= de1 ? slice(s_g) : '0;
            VGA_B  <= de1 ? slice(s_b) : '0;
            VGA_HS <= hs1;
            VGA_VS <= vs1;
            VGA_DE <= de1;
        end
    end

endmodule

// File: tb/tb_vga_depth_dither.sv
// Directed bench for vga_depth_dither at 8->6 bits, N=2, active-low sync.
module tb_vga_depth_dither;

    logic       CLOCK_27 = 1'b0;
    logic       RESET_N  = 1'b0;
    logic       CE_PIX   = 1'b0;
    logic [1:0] MODE     = 2'b00;
    logic       HS_IN    = 1'b1;
    logic       VS_IN    = 1'b1;
    logic       DE_IN    = 1'b0;
    logic [7:0] R_IN     = 8'h00;
    logic [7:0] G_IN     = 8'h00;
    logic [7:0] B_IN     = 8'h00;
    logic       VGA_HS, VGA_VS, VGA_DE;
    logic [5:0] VGA_R, VGA_G, VGA_B;

    int n_chk  = 0;
    int n_fail = 0;

    vga_depth_dither #(.IN_W(8), .OUT_W(6), .MATRIX(2), .SYNC_P(1'b0)) dut (
        .CLOCK_27(CLOCK_27), .RESET_N(RESET_N), .CE_PIX(CE_PIX), .MODE(MODE),
        .HS_IN(HS_IN), .VS_IN(VS_IN), .DE_IN(DE_IN),
        .R_IN(R_IN), .G_IN(G_IN), .B_IN(B_IN),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_DE(VGA_DE),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    always #5 CLOCK_27 = ~CLOCK_27;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_27);
        #1;
    endtask

    task automatic pix(input logic de, input logic [7:0] v);
        DE_IN = de;
        R_IN  = v;
        G_IN  = v;
        B_IN  = v;
        step();
    endtask

    // HS and VS fall together so the VS edge wins and y restarts at 0.
    task automatic frame_start();
        DE_IN = 1'b0;
        HS_IN = 1'b0;
        VS_IN = 1'b0;
        step();
        step();
        HS_IN = 1'b1;
        VS_IN = 1'b1;
        step();
    endtask

    task automatic line_start();
        DE_IN = 1'b0;
        HS_IN = 1'b0;
        step();
        HS_IN = 1'b1;
        step();
    endtask

    // Two active pixels of value v, then blanking; checks both outputs in order.
    task automatic line2(input string tag, input logic [7:0] v,
                         input logic [5:0] e0, input logic [5:0] e1,
                         output logic [7:0] sum);
        logic [5:0] o0;
        pix(1'b1, v);
        pix(1'b1, v);
        o0 = VGA_R;
        check({tag, "_x0"}, VGA_R, e0);
        pix(1'b0, 8'h00);
        check({tag, "_x1"}, VGA_R, e1);
        sum = 8'(o0) + 8'(VGA_R);
        pix(1'b0, 8'h00);
    endtask

    logic [7:0] s0, s1;

    initial begin
        // Reset state
        step();
        step();
        check("rst_r", VGA_R, 6'h00);
        check("rst_de", VGA_DE, 1'b0);
        check("rst_hs", VGA_HS, 1'b1);
        check("rst_vs", VGA_VS, 1'b1);
        #2;
        RESET_N = 1'b1;
        CE_PIX  = 1'b1;
        step();

        // T1: truncate, latency and CE hold
        DE_IN = 1'b1; R_IN = 8'h87; G_IN = 8'h40; B_IN = 8'hFF;
        step();
        check("t1_lat1_de", VGA_DE, 1'b0);
        pix(1'b0, 8'h00);
        check("t1_r", VGA_R, 6'h21);
        check("t1_g", VGA_G, 6'h10);
        check("t1_b", VGA_B, 6'h3F);
        check("t1_de", VGA_DE, 1'b1);
        CE_PIX = 1'b0;
        DE_IN = 1'b1; R_IN = 8'h55; HS_IN = 1'b0;
        repeat (5) @(posedge CLOCK_27);
        #1;
        check("t1_hold_r", VGA_R, 6'h21);
        check("t1_hold_de", VGA_DE, 1'b1);
        check("t1_hold_hs", VGA_HS, 1'b1);
        HS_IN = 1'b1;
        CE_PIX = 1'b1;
        pix(1'b0, 8'h00);
        pix(1'b0, 8'h00);

        // T2: round
        MODE = 2'b01;
        frame_start();
        pix(1'b1, 8'h86);
        pix(1'b1, 8'hFF);
        check("t2_round", VGA_R, 6'h22);
        pix(1'b0, 8'h00);
        check("t2_sat_r", VGA_R, 6'h3F);
        check("t2_sat_b", VGA_B, 6'h3F);
        pix(1'b0, 8'h00);

        // T5: mode change mid-frame stays truncated; blanking; sync delay
        MODE = 2'b00;
        frame_start();
        MODE = 2'b10;
        line2("t5_trunc", 8'h86, 6'h21, 6'h21, s0);
        DE_IN = 1'b0; R_IN = 8'hFF; G_IN = 8'hFF; B_IN = 8'hFF; HS_IN = 1'b0;
        step();
        check("t5_hs_d1", VGA_HS, 1'b1);
        step();
        check("t5_hs_d2", VGA_HS, 1'b0);
        check("t5_blank_r", VGA_R, 6'h00);
        check("t5_blank_de", VGA_DE, 1'b0);
        HS_IN = 1'b1;
        step();
        check("t5_hs_d3", VGA_HS, 1'b0);
        step();
        check("t5_hs_d4", VGA_HS, 1'b1);

        // T3: ordered dither, VS delay checked on the way in
        DE_IN = 1'b0; HS_IN = 1'b0; VS_IN = 1'b0;
        step();
        check("t3_vs_d1", VGA_VS, 1'b1);
        step();
        check("t3_vs_d2", VGA_VS, 1'b0);
        HS_IN = 1'b1; VS_IN = 1'b1;
        step();
        check("t3_vs_d3", VGA_VS, 1'b0);
        step();
        check("t3_vs_d4", VGA_VS, 1'b1);
        line2("t3_l0", 8'h85, 6'h21, 6'h21, s0);
        line_start();
        line2("t3_l1", 8'h85, 6'h22, 6'h21, s1);
        check("t3_sum2x2", s0 + s1, 8'h85);

        // T4: temporal; first frame f=0 matches ordered, second frame f=1 flips indices
        MODE = 2'b11;
        frame_start();
        line2("t4a_l0", 8'h85, 6'h21, 6'h21, s0);
        line_start();
        line2("t4a_l1", 8'h85, 6'h22, 6'h21, s1);
        frame_start();
        line2("t4b_l0", 8'h85, 6'h21, 6'h22, s0);
        line_start();
        line2("t4b_l1", 8'h85, 6'h21, 6'h21, s1);

        // T6: async reset mid-line, then truncate until the next VS edge
        DE_IN = 1'b1; R_IN = 8'hFF; G_IN = 8'hFF; B_IN = 8'hFF; HS_IN = 1'b0;
        step();
        step();
        check("t6_pre_r", VGA_R, 6'h3F);
        check("t6_pre_hs", VGA_HS, 1'b0);
        #2;
        RESET_N = 1'b0;
        #1;
        check("t6_async_r", VGA_R, 6'h00);
        check("t6_async_de", VGA_DE, 1'b0);
        check("t6_async_hs", VGA_HS, 1'b1);
        check("t6_async_vs", VGA_VS, 1'b1);
        DE_IN = 1'b0; HS_IN = 1'b1;
        step();
        step();
        RESET_N = 1'b1;
        step();
        line2("t6_trunc", 8'h86, 6'h21, 6'h21, s0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
